// File: rtl/conv1d_stream.sv
// Streaming 1-D convolution: K-tap sliding window, NF filters sharing one tap per clock,
// with per-filter bias, requantising shift, symmetric saturation and optional ReLU.
module conv1d_stream #(
   parameter int DATA_W = 8,
   parameter int K      = 5,
   parameter int NF     = 4,
   parameter int ACC_W  = 19,
   parameter int SHIFT  = 7,
   parameter int STRIDE = 1,
   parameter int RELU   = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [DATA_W-1:0]    in_data,
   input  logic                        in_first,
   input  logic                        coef_we,
   input  logic [$clog2(NF)-1:0]       coef_sel,
   input  logic [$clog2(K)-1:0]        coef_tap,
   input  logic signed [DATA_W-1:0]    coef_data,
   input  logic                        bias_we,
   input  logic signed [ACC_W-1:0]     bias_data,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NF*DATA_W-1:0]        out_data
);

   localparam int CW = $clog2(K + 1);
   localparam int TW = $clog2(K);
   localparam int PW = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = -MAXV;

   typedef enum logic [1:0] {
      S_FILL,
      S_COMPUTE,
      S_SAT,
      S_OUT
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]              fill_cnt;
   logic                       primed;
   logic [TW-1:0]              tap;
   logic signed [DATA_W-1:0]   win  [K];
   logic signed [DATA_W-1:0]   coef [NF][K];
   logic signed [ACC_W-1:0]    bias [NF];
   logic signed [ACC_W-1:0]    acc  [NF];
   logic signed [PW-1:0]       prod [NF];
   logic signed [DATA_W-1:0]   sat_res [NF];

   logic          xfer;
   logic          fill_done;
   logic          cfg_ok;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] target;

   assign in_ready  = en && (state == S_FILL);
   assign busy      = (state != S_FILL);
   assign xfer      = in_valid && in_ready;
   assign cfg_ok    = en && !busy;
   assign cnt_next  = in_first ? CW'(1) : fill_cnt + CW'(1);
   // A fresh frame (or the first one after reset) needs a full window; later outputs only STRIDE samples
   assign target    = (in_first || !primed) ? CW'(K) : CW'(STRIDE);
   assign fill_done = xfer && (cnt_next == target);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; en=0 freezes the FSM
   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            S_FILL:    if (fill_done) state_nxt = S_COMPUTE;
            S_COMPUTE: if (tap == TW'(K - 1)) state_nxt = S_SAT;
            S_SAT:     state_nxt = S_OUT;
            S_OUT:     if (out_ready) state_nxt = S_FILL;
            default:   state_nxt = S_FILL;
         endcase
      end
   end

   // One tap product per filter, operands sign-extended before the multiply
   always_comb begin
      for (int f = 0; f < NF; f++) begin
         prod[f] = PW'(coef[f][tap]) * PW'(win[tap]);
      end
   end

   // Requantise: floor shift, symmetric clamp, then optional ReLU
   always_comb begin
      logic signed [ACC_W-1:0] sh;
      for (int f = 0; f < NF; f++) begin
         sh = acc[f] >>> SHIFT;
         if (sh > MAXV) begin
            sh = MAXV;
         end else if (sh < MINV) begin
            sh = MINV;
         end
         if ((RELU != 0) && (sh < 0)) begin
            sh = '0;
         end
         sat_res[f] = sh[DATA_W-1:0];
      end
   end

   // Datapath: window, coefficient store, accumulators and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt  <= '0;
         primed    <= 1'b0;
         tap       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int k = 0; k < K; k++) begin
            win[k] <= '0;
         end
         for (int f = 0; f < NF; f++) begin
            acc[f]  <= '0;
            bias[f] <= '0;
            for (int k = 0; k < K; k++) begin
               coef[f][k] <= '0;
            end
         end
      end else if (en) begin
         if (cfg_ok && coef_we && (int'(coef_sel) < NF) && (int'(coef_tap) < K)) begin
            coef[coef_sel][coef_tap] <= coef_data;
         end
         if (cfg_ok && bias_we && (int'(coef_sel) < NF)) begin
            bias[coef_sel] <= bias_data;
         end
         case (state)
            S_FILL: begin
               if (xfer) begin
                  win[0] <= in_data;
                  for (int k = 1; k < K; k++) begin
                     win[k] <= win[k-1];
                  end
                  if (fill_done) begin
                     fill_cnt <= '0;
                     primed   <= 1'b1;
                     tap      <= '0;
                     // A bias written on this same edge must already seed this computation
                     for (int f = 0; f < NF; f++) begin
                        acc[f] <= (bias_we && (int'(coef_sel) == f)) ? bias_data : bias[f];
                     end
                  end else begin
                     fill_cnt <= cnt_next;
                     if (in_first) begin
                        primed <= 1'b0;
                     end
                  end
               end
            end
            S_COMPUTE: begin
               tap <= tap + TW'(1);
               for (int f = 0; f < NF; f++) begin
                  acc[f] <= acc[f] + ACC_W'(prod[f]);
               end
            end
            S_SAT: begin
               out_valid <= 1'b1;
               for (int f = 0; f < NF; f++) begin
                  out_data[f*DATA_W +: DATA_W] <= sat_res[f];
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv1d_stream.sv
// Self-checking bench for conv1d_stream: two instances (ReLU off/on, stride 2) share one
// stimulus stream and are compared against a windowed dot-product reference model.
module tb_conv1d_stream;

   localparam int DATA_W = 8;
   localparam int K      = 5;
   localparam int NF     = 4;
   localparam int ACC_W  = 19;
   localparam int SHIFT  = 7;
   localparam int STRIDE = 2;
   localparam int MAXV   = (2 ** (DATA_W - 1)) - 1;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       en;
   logic                       in_valid;
   logic signed [DATA_W-1:0]   in_data;
   logic                       in_first;
   logic                       coef_we;
   logic [$clog2(NF)-1:0]      coef_sel;
   logic [$clog2(K)-1:0]       coef_tap;
   logic signed [DATA_W-1:0]   coef_data;
   logic                       bias_we;
   logic signed [ACC_W-1:0]    bias_data;
   logic                       out_ready;

   logic                       in_ready_a, busy_a, out_valid_a;
   logic [NF*DATA_W-1:0]       out_data_a;
   logic                       in_ready_b, busy_b, out_valid_b;
   logic [NF*DATA_W-1:0]       out_data_b;

   int n_checks = 0;
   int n_pass   = 0;

   int m_coef [NF][K];
   int m_bias [NF];
   int hist [$];

   always #5 clk = ~clk;

   conv1d_stream #(
      .DATA_W(DATA_W), .K(K), .NF(NF), .ACC_W(ACC_W), .SHIFT(SHIFT), .STRIDE(STRIDE), .RELU(0)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_first(in_first),
      .coef_we(coef_we), .coef_sel(coef_sel), .coef_tap(coef_tap), .coef_data(coef_data),
      .bias_we(bias_we), .bias_data(bias_data),
      .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
   );

   conv1d_stream #(
      .DATA_W(DATA_W), .K(K), .NF(NF), .ACC_W(ACC_W), .SHIFT(SHIFT), .STRIDE(STRIDE), .RELU(1)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_first(in_first),
      .coef_we(coef_we), .coef_sel(coef_sel), .coef_tap(coef_tap), .coef_data(coef_data),
      .bias_we(bias_we), .bias_data(bias_data),
      .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int lane(input logic [NF*DATA_W-1:0] v, input int f);
      logic signed [DATA_W-1:0] x;
      x = v[f*DATA_W +: DATA_W];
      return int'(x);
   endfunction

   // Reference: bias + sum of coef[t] * (sample t transfers ago), wrapped to ACC_W,
   // floor-divided by 2^SHIFT, clamped to +/-MAXV, optionally rectified
   function automatic int model_out(input int f, input bit relu);
      longint s;
      logic signed [ACC_W-1:0] a;
      int r;
      s = longint'(m_bias[f]);
      for (int t = 0; t < K; t++) begin
         s += longint'(m_coef[f][t]) * longint'(hist[t]);
      end
      a = s[ACC_W-1:0];
      r = int'(a) >>> SHIFT;
      if (r > MAXV) r = MAXV;
      if (r < -MAXV) r = -MAXV;
      if (relu && r < 0) r = 0;
      return r;
   endfunction

   task automatic modelReset();
      for (int f = 0; f < NF; f++) begin
         m_bias[f] = 0;
         for (int t = 0; t < K; t++) m_coef[f][t] = 0;
      end
      hist.delete();
      repeat (K) hist.push_back(0);
   endtask

   task automatic writeCoef(input int f, input int t, input int v);
      coef_sel  = f[$clog2(NF)-1:0];
      coef_tap  = t[$clog2(K)-1:0];
      coef_data = DATA_W'(v);
      coef_we   = 1'b1;
      tick();
      coef_we   = 1'b0;
      m_coef[f][t] = v;
   endtask

   task automatic writeBias(input int f, input int v);
      coef_sel  = f[$clog2(NF)-1:0];
      bias_data = ACC_W'(v);
      bias_we   = 1'b1;
      tick();
      bias_we   = 1'b0;
      m_bias[f] = v;
   endtask

   task automatic applyStimulus(input int d, input bit first);
      int n;
      in_data  = DATA_W'(d);
      in_first = first;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready_a && n < 20) begin
         tick();
         n++;
      end
      checkOutput("xfer:in_ready", int'(in_ready_a), 1);
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
      coef_we  = 1'b0;
      bias_we  = 1'b0;
      hist.push_front(d);
      if (hist.size() > K) void'(hist.pop_back());
   endtask

   task automatic sendFrame(input int s0, input int s1, input int s2, input int s3, input int s4);
      applyStimulus(s0, 1'b1);
      applyStimulus(s1, 1'b0);
      applyStimulus(s2, 1'b0);
      applyStimulus(s3, 1'b0);
      applyStimulus(s4, 1'b0);
   endtask

   task automatic waitResult(input string tag, input int en_gap);
      int n;
      n = 0;
      if (en_gap > 0) begin
         tick();
         tick();
         n = 2;
         en = 1'b0;
         repeat (en_gap) begin
            tick();
            n++;
         end
         checkOutput({tag, ":frozen_ready"}, int'(in_ready_a), 0);
         checkOutput({tag, ":frozen_busy"}, int'(busy_a), 1);
         en = 1'b1;
      end
      while (!out_valid_a && n < 60) begin
         tick();
         n++;
      end
      checkOutput({tag, ":latency"}, n, K + 1 + en_gap);
      checkOutput({tag, ":busy"}, int'(busy_a), 1);
      checkOutput({tag, ":in_ready"}, int'(in_ready_a), 0);
      checkOutput({tag, ":valid_b"}, int'(out_valid_b), 1);
      for (int f = 0; f < NF; f++) begin
         checkOutput($sformatf("%s:a_f%0d", tag, f), lane(out_data_a, f), model_out(f, 1'b0));
         checkOutput($sformatf("%s:b_f%0d", tag, f), lane(out_data_b, f), model_out(f, 1'b1));
      end
   endtask

   task automatic releaseResult(input string tag, input int hold);
      for (int c = 0; c < hold; c++) begin
         in_valid  = 1'b1;
         in_data   = 8'sd99;
         coef_we   = 1'b1;
         coef_sel  = '0;
         coef_tap  = '0;
         coef_data = -8'sd1;
         bias_we   = 1'b1;
         bias_data = 19'sd1000;
         tick();
         checkOutput({tag, ":hold_valid"}, int'(out_valid_a), 1);
         checkOutput({tag, ":hold_ready"}, int'(in_ready_a), 0);
         checkOutput({tag, ":hold_f0"}, lane(out_data_a, 0), model_out(0, 1'b0));
      end
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      bias_we   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, ":done_valid"}, int'(out_valid_a), 0);
      checkOutput({tag, ":done_ready"}, int'(in_ready_a), 1);
      checkOutput({tag, ":done_busy"}, int'(busy_a), 0);
   endtask

   initial begin
      int rf, rt, rv, rb;
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0;
      coef_we = 1'b0; coef_sel = '0; coef_tap = '0; coef_data = '0;
      bias_we = 1'b0; bias_data = '0; out_ready = 1'b0;
      modelReset();
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset:out_valid", int'(out_valid_a), 0);
      checkOutput("reset:busy", int'(busy_a), 0);
      checkOutput("reset:in_ready", int'(in_ready_a), 1);
      checkOutput("reset:data_a", lane(out_data_a, 0), 0);
      checkOutput("reset:data_b", lane(out_data_b, 3), 0);

      $display("[TB] directed kernel on filter 0");
      writeCoef(0, 0, 106); writeCoef(0, 1, -86); writeCoef(0, 2, 27);
      writeCoef(0, 3, 69);  writeCoef(0, 4, 68);
      sendFrame(10, 20, 30, 40, 50);
      waitResult("basic", 0);
      checkOutput("basic:f0_const", lane(out_data_a, 0), 36);
      releaseResult("basic", 0);

      $display("[TB] stride and output back-pressure");
      applyStimulus(60, 1'b0);
      checkOutput("stride:no_trigger", int'(busy_a), 0);
      applyStimulus(70, 1'b0);
      waitResult("stride", 0);
      checkOutput("stride:f0_const", lane(out_data_a, 0), 65);
      releaseResult("stride", 10);
      applyStimulus(80, 1'b0);
      applyStimulus(90, 1'b0);
      waitResult("after_hold", 0);
      releaseResult("after_hold", 0);

      $display("[TB] saturation");
      for (int f = 0; f < NF; f++)
         for (int t = 0; t < K; t++) writeCoef(f, t, 127);
      sendFrame(127, 127, 127, 127, 127);
      waitResult("sat_pos", 0);
      checkOutput("sat_pos:f3_const", lane(out_data_a, 3), 127);
      releaseResult("sat_pos", 0);
      for (int f = 0; f < NF; f++)
         for (int t = 0; t < K; t++) writeCoef(f, t, -127);
      sendFrame(127, 127, 127, 127, 127);
      waitResult("sat_neg", 0);
      checkOutput("sat_neg:a_const", lane(out_data_a, 0), -127);
      checkOutput("sat_neg:b_const", lane(out_data_b, 0), 0);
      releaseResult("sat_neg", 0);

      $display("[TB] bias");
      for (int f = 0; f < NF; f++)
         for (int t = 0; t < K; t++) writeCoef(f, t, 0);
      writeCoef(0, 0, 106); writeCoef(0, 1, -86); writeCoef(0, 2, 27);
      writeCoef(0, 3, 69);  writeCoef(0, 4, 68);
      writeBias(0, 128);
      sendFrame(10, 20, 30, 40, 50);
      waitResult("bias", 0);
      checkOutput("bias:f0_const", lane(out_data_a, 0), 37);
      releaseResult("bias", 0);

      $display("[TB] reset during compute");
      sendFrame(5, 6, 7, 8, 9);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelReset();
      checkOutput("midrst:out_valid", int'(out_valid_a), 0);
      checkOutput("midrst:busy", int'(busy_a), 0);
      checkOutput("midrst:in_ready", int'(in_ready_a), 1);
      for (int i = 0; i < K - 1; i++) begin
         applyStimulus(11 * (i + 1), 1'b0);
         checkOutput($sformatf("midrst:refill%0d", i), int'(busy_a), 0);
      end
      applyStimulus(100, 1'b0);
      waitResult("midrst", 0);
      releaseResult("midrst", 0);

      $display("[TB] randomized frames");
      for (int it = 0; it < 4; it++) begin
         for (int f = 0; f < NF; f++) begin
            for (int t = 0; t < K; t++) writeCoef(f, t, int'($urandom_range(255)) - 128);
            writeBias(f, int'($urandom_range(8000)) - 4000);
         end
         applyStimulus(int'($urandom_range(255)) - 128, 1'b1);
         for (int i = 1; i < K - 1; i++) applyStimulus(int'($urandom_range(255)) - 128, 1'b0);
         rf = int'($urandom_range(NF - 1));
         rt = int'($urandom_range(K - 1));
         rv = int'($urandom_range(255)) - 128;
         rb = int'($urandom_range(8000)) - 4000;
         coef_sel  = rf[$clog2(NF)-1:0];
         coef_tap  = rt[$clog2(K)-1:0];
         coef_data = DATA_W'(rv);
         bias_data = ACC_W'(rb);
         coef_we   = 1'b1;
         bias_we   = 1'b1;
         m_coef[rf][rt] = rv;
         m_bias[rf]     = rb;
         applyStimulus(int'($urandom_range(255)) - 128, 1'b0);
         waitResult($sformatf("rand%0d", it), (it == 1) ? 3 : 0);
         releaseResult("rand", 0);
         for (int i = 0; i < STRIDE; i++) applyStimulus(int'($urandom_range(255)) - 128, 1'b0);
         waitResult($sformatf("rand%0d_stride", it), 0);
         releaseResult("rand_stride", 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
